// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position display.
// State enum, status-byte bit indices and the active-low hex segment table.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ENC  = 2'd2
    } state_t;

    // Bit positions inside the PS/2 status byte
    localparam int B0_L     = 0;
    localparam int B0_R     = 1;
    localparam int B0_M     = 2;
    localparam int B0_ONE   = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low, bit 0 = a ... bit 6 = g; entry 15 first
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, // F
        7'b0000110, // E
        7'b0100001, // d
        7'b1000110, // C
        7'b0000011, // b
        7'b0001000, // A
        7'b0010000, // 9
        7'b0000000, // 8
        7'b1111000, // 7
        7'b0000010, // 6
        7'b0010010, // 5
        7'b0011001, // 4
        7'b0110000, // 3
        7'b0100100, // 2
        7'b1111001, // 1
        7'b1000000  // 0
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/ps2_mouse_pos_display_hex_to_sevseg.sv
// Combinational 4-bit to 7-bit active-low seven-segment decoder.
// Ports: nib (hex digit in), seg (segment pattern out, bit 0 = a).
import ps2_mouse_pkg::*;

module hex_to_sevseg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_seg(nib);

endmodule

// File: rtl/ps2_mouse_pos_display.sv
// Accumulates PS/2 mouse packets into a clamped X/Y position shown as "XXYY".
// Ports: clk, rst (sync, high), pkt_valid/pkt_ready/pkt_byte0..2 packet in,
//        sevseg_1..4 active-low digits (Y lo, Y hi, X lo, X hi), held.
import ps2_mouse_pkg::*;

module ps2_mouse_pos_display #(
    parameter int POS_MAX   = 255,
    parameter int DIV_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [7:0] pkt_byte0,
    input  logic [7:0] pkt_byte1,
    input  logic [7:0] pkt_byte2,
    output logic [6:0] sevseg_1,
    output logic [6:0] sevseg_2,
    output logic [6:0] sevseg_3,
    output logic [6:0] sevseg_4,
    output logic       held
);

    localparam logic [7:0]        CENTRE = 8'((POS_MAX + 1) / 2);
    localparam logic signed [10:0] MAX_S = 11'(POS_MAX);

    state_t     state;
    state_t     state_n;
    logic       accept;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] x;
    logic [7:0] y;
    logic       prev_r;
    logic       held_n;
    logic [6:0] dec_1;
    logic [6:0] dec_2;
    logic [6:0] dec_3;
    logic [6:0] dec_4;
    logic       unused_b0;

    // The constant-one and middle-button bits carry no meaning here
    assign unused_b0 = ^b0[B0_ONE:B0_M];

    // Floor-shift the signed 9-bit delta, then add and clamp in 11 bits
    function automatic logic [7:0] step(
        input logic [7:0] pos,
        input logic       sgn,
        input logic [7:0] mag,
        input logic       ovf
    );
        logic signed [8:0]  d;
        logic signed [10:0] s;
        d = $signed({sgn, mag}) >>> DIV_SHIFT;
        if (ovf) begin
            d = '0;
        end
        s = $signed({3'b000, pos}) + $signed({{2{d[8]}}, d});
        if (s[10]) begin
            return 8'd0;
        end else if (s > MAX_S) begin
            return 8'(POS_MAX);
        end
        return s[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        pkt_ready = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC:    state_n = ENC;
            ENC:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A right-button rising edge flips hold before motion is considered
    assign held_n = held ^ (b0[B0_R] & ~prev_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            b0       <= '0;
            b1       <= '0;
            b2       <= '0;
            x        <= CENTRE;
            y        <= CENTRE;
            held     <= 1'b0;
            prev_r   <= 1'b0;
            sevseg_1 <= hex_seg(CENTRE[3:0]);
            sevseg_2 <= hex_seg(CENTRE[7:4]);
            sevseg_3 <= hex_seg(CENTRE[3:0]);
            sevseg_4 <= hex_seg(CENTRE[7:4]);
        end else begin
            if (accept) begin
                b0 <= pkt_byte0;
                b1 <= pkt_byte1;
                b2 <= pkt_byte2;
            end
            if (state == CALC) begin
                prev_r <= b0[B0_R];
                held   <= held_n;
                if (held_n) begin
                    x <= x;
                    y <= y;
                end else if (b0[B0_L]) begin
                    x <= CENTRE;
                    y <= CENTRE;
                end else begin
                    x <= step(x, b0[B0_XSIGN], b1, b0[B0_XOVF]);
                    y <= step(y, b0[B0_YSIGN], b2, b0[B0_YOVF]);
                end
            end
            if (state == ENC) begin
                sevseg_1 <= dec_1;
                sevseg_2 <= dec_2;
                sevseg_3 <= dec_3;
                sevseg_4 <= dec_4;
            end
        end
    end

    hex_to_sevseg u_y_lo (.nib(y[3:0]), .seg(dec_1));
    hex_to_sevseg u_y_hi (.nib(y[7:4]), .seg(dec_2));
    hex_to_sevseg u_x_lo (.nib(x[3:0]), .seg(dec_3));
    hex_to_sevseg u_x_hi (.nib(x[7:4]), .seg(dec_4));

endmodule
